pipeline_scheduler: RTL and testbench
=====================================

PIPELINE_SCHEDULER -- requirements
Module: pipeline_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: instruction buffer entries; power of two, range 2 to 16.
REQ-002 Parameter HAZARD_WIN, default 2: cycles from issue until the destination register is written back.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 Port in_valid, input, 1: requester presents an instruction.
REQ-006 Port in_instr, input, 17: [16:15] opcode, [14:10] dest, [9:5] srcA, [4:0] srcB.
REQ-007 Port in_ready, output, 1: buffer can accept; high when the buffer is not full.
REQ-008 Port flush, input, 1: discard buffered instructions and drain the datapath.
REQ-009 Port issue_instr, output, 17: registered instruction driven to the datapath each cycle.
REQ-010 Port issue_valid, output, 1: issue_instr is a real instruction, not a bubble.
REQ-011 Port busy, output, 1: buffer non-empty or any in-flight write pending.
REQ-012 Port issued_cnt, output, 16: count of real instructions issued.
REQ-013 Port stall_cnt, output, 16: count of bubbles inserted due to hazards.

Function
REQ-014 Accept: an instruction is written into the FIFO when in_valid and in_ready are both high on the same edge.
REQ-015 Opcodes 00 (add), 01 (sub) and 10 (ternary) write register dest; opcode 11 is a NOP with no register write.
REQ-016 Bubble value: issue_instr = 17'b11_00000_00000_00000 with issue_valid = 0.
REQ-017 Scoreboard: a shift register of HAZARD_WIN entries, each {valid, dest}, recording every issued writing instruction; it shifts every cycle, and a bubble inserts an invalid entry.
REQ-018 Hazard: the FIFO head conflicts when its srcA or srcB equals the dest of any valid scoreboard entry.
REQ-019 The head opcode does not mask the hazard check; a NOP head is checked like any other instruction.
REQ-020 Register 0 is not special; a dest or src of 0 is compared like any other register.
REQ-021 State IDLE: FIFO empty; drive a bubble; go to ISSUE when the FIFO becomes non-empty.
REQ-022 State ISSUE: with no conflict, pop the head and drive it next cycle with issue_valid = 1 and issued_cnt + 1.
REQ-023 ISSUE on conflict: go to STALL, drive a bubble, and increment stall_cnt.
REQ-024 State STALL: re-evaluate the head every cycle, adding one bubble and one stall_cnt per cycle, and return to ISSUE once the conflict clears.
REQ-025 State DRAIN: entered on flush from any state.
REQ-026 In DRAIN: clear the FIFO that cycle, drive bubbles, and hold in_ready = 0.
REQ-027 DRAIN exit: go to IDLE once the scoreboard holds no valid entries (HAZARD_WIN cycles).
REQ-028 Flush priority: flush overrides a simultaneous accept (the word is dropped) and a simultaneous issue (a bubble is driven instead).
REQ-029 Simultaneous accept and pop on a full FIFO is not permitted; in_ready = 0 when full, regardless of a pop that cycle.
REQ-030 Simultaneous accept and pop on a non-full FIFO leaves the occupancy unchanged.
REQ-031 Pointers wrap modulo DEPTH; the occupancy counter is log2(DEPTH)+1 bits.
REQ-032 Throughput: with no hazards and a non-empty FIFO, the block issues one instruction per cycle.
REQ-033 Latency: minimum latency from accept to issue_valid is 2 cycles.
REQ-034 issued_cnt and stall_cnt wrap from 16'hFFFF to 0 without saturation.
REQ-035 In_valid while in_ready = 0 is ignored and the instruction is not stored.

Reset
REQ-036 On a reset_n low edge: state = IDLE, FIFO empty, scoreboard invalid, issue_instr = bubble, issue_valid = 0.
REQ-037 On a reset_n low edge: busy = 0, issued_cnt = 0, stall_cnt = 0, and in_ready = 0 during the reset cycle.
REQ-038 Reset mid-operation discards all buffered and in-flight tracking state; the first accept is possible on the cycle after reset_n goes high.

Structure
REQ-039 Shared package: opcode constants (OP_ADD=00, OP_SUB=01, OP_TERN=10, OP_NOP=11), the BUBBLE constant, the state enumeration, and instruction field offsets.
REQ-040 One sub-module, sched_fifo, implements the DEPTH x 17 buffer with push, pop, full, empty and count; the scoreboard and FSM reside in the top level.

Verification
REQ-041 Independent stream: push 00_00100_00000_00001, 01_00101_00001_00010, 10_00110_00010_00011 back-to-back -> three consecutive issue_valid cycles, stall_cnt = 0, issued_cnt = 3.
REQ-042 RAW hazard: push 00_00100_00000_00001 then 01_00101_00100_00010 -> two bubbles between the issues, stall_cnt = 2.
REQ-043 Full buffer: push 5 instructions with a conflicting head -> in_ready = 0 after 4 accepts, the 5th is not stored, and order is preserved on issue.
REQ-044 Flush: flush while 3 instructions are buffered and 1 is in flight -> no further issue_valid, DRAIN for 2 cycles, then IDLE with busy = 0.
REQ-045 Reset mid-stall: reset_n low during STALL -> the next cycle shows all outputs at reset values and the counters at 0.
REQ-046 Counter wrap: preload issued_cnt = 16'hFFFF via hierarchical force, issue 1 -> issued_cnt = 0.

Source files
------------

// File: rtl/pipeline_scheduler_pkg.sv
// Shared definitions for the pipeline scheduler: instruction layout, opcodes,
// the bubble word and the FSM state encoding.
package pipeline_scheduler_pkg;

    localparam int INSTR_W = 17;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 16;

    localparam int OP_HI   = 16;
    localparam int OP_LO   = 15;
    localparam int DEST_HI = 14;
    localparam int DEST_LO = 10;
    localparam int SRCA_HI = 9;
    localparam int SRCA_LO = 5;
    localparam int SRCB_HI = 4;
    localparam int SRCB_LO = 0;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OP_ADD  = 2'b00;
    localparam opcode_t OP_SUB  = 2'b01;
    localparam opcode_t OP_TERN = 2'b10;
    localparam opcode_t OP_NOP  = 2'b11;

    localparam logic [INSTR_W-1:0] BUBBLE = 17'b11_00000_00000_00000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_STALL,
        S_DRAIN
    } sched_state_t;

    // Only NOP leaves the register file untouched.
    function automatic logic writes_reg(input opcode_t op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/pipeline_scheduler_if.sv
// Requester/datapath bundle of the pipeline scheduler; clock and reset stay
// outside the interface.
interface pipeline_scheduler_if;
    import pipeline_scheduler_pkg::*;

    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               flush;
    logic [INSTR_W-1:0] issue_instr;
    logic               issue_valid;
    logic               busy;
    logic [CNT_W-1:0]   issued_cnt;
    logic [CNT_W-1:0]   stall_cnt;

    // A word transfers on a rising edge where in_valid and in_ready are both
    // high; in_valid may be raised without waiting for in_ready, and a
    // same-cycle flush drops the word.
    modport master (
        output in_valid, in_instr, flush,
        input  in_ready, issue_instr, issue_valid, busy, issued_cnt, stall_cnt
    );

    modport slave (
        input  in_valid, in_instr, flush,
        output in_ready, issue_instr, issue_valid, busy, issued_cnt, stall_cnt
    );

endinterface

// File: rtl/pipeline_scheduler_fifo.sv
// DEPTH-entry instruction buffer with a synchronous clear; the head word is
// presented combinationally on dout.
module sched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/pipeline_scheduler.sv
// In-order issue stage: buffers instructions, holds back a head whose sources
// match a write still in flight, and drains cleanly on flush.
module pipeline_scheduler
    import pipeline_scheduler_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int HAZARD_WIN = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    pipeline_scheduler_if.slave  bus,
    output sched_state_t         dbg_state
);
    sched_state_t state, state_next;

    logic [INSTR_W-1:0]    fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_push;
    logic                  fifo_clear;
    logic                  do_pop;
    logic                  do_stall;
    logic                  conflict;
    logic                  sb_any;

    logic [HAZARD_WIN-1:0]            sb_valid;
    logic [HAZARD_WIN-1:0][REG_W-1:0] sb_dest;

    logic [INSTR_W-1:0] issue_instr_q;
    logic               issue_valid_q;
    logic [CNT_W-1:0]   issued_q;
    logic [CNT_W-1:0]   stall_q;

    assign bus.in_ready = reset_n && !fifo_full && (state != S_DRAIN);
    assign fifo_push    = bus.in_valid && bus.in_ready && !bus.flush;

    sched_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (fifo_clear),
        .push    (fifo_push),
        .pop     (do_pop),
        .din     (bus.in_instr),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Every head is checked, NOP included, and r0 is an ordinary register.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < HAZARD_WIN; i++) begin
            if (sb_valid[i] &&
                ((sb_dest[i] == fifo_head[SRCA_HI:SRCA_LO]) ||
                 (sb_dest[i] == fifo_head[SRCB_HI:SRCB_LO]))) begin
                conflict = 1'b1;
            end
        end
    end

    assign sb_any = |sb_valid;

    always_comb begin
        state_next = state;
        do_pop     = 1'b0;
        do_stall   = 1'b0;
        fifo_clear = 1'b0;
        if (bus.flush) begin
            state_next = S_DRAIN;
            fifo_clear = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) state_next = S_ISSUE;
                end
                S_ISSUE, S_STALL: begin
                    if (fifo_empty) begin
                        state_next = S_IDLE;
                    end else if (conflict) begin
                        state_next = S_STALL;
                        do_stall   = 1'b1;
                    end else begin
                        state_next = S_ISSUE;
                        do_pop     = 1'b1;
                    end
                end
                S_DRAIN: begin
                    fifo_clear = 1'b1;
                    if (!sb_any) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            issue_instr_q <= BUBBLE;
            issue_valid_q <= 1'b0;
            sb_valid      <= '0;
            sb_dest       <= '0;
            issued_q      <= '0;
            stall_q       <= '0;
        end else begin
            state         <= state_next;
            issue_valid_q <= do_pop;
            issue_instr_q <= do_pop ? fifo_head : BUBBLE;
            // Slot 0 takes the word issued this edge; bubbles enter as invalid.
            sb_valid[0]   <= do_pop && writes_reg(fifo_head[OP_HI:OP_LO]);
            sb_dest[0]    <= fifo_head[DEST_HI:DEST_LO];
            for (int i = 1; i < HAZARD_WIN; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_dest[i]  <= sb_dest[i-1];
            end
            if (do_pop)   issued_q <= issued_q + 16'd1;
            if (do_stall) stall_q  <= stall_q + 16'd1;
        end
    end

    assign bus.issue_instr = issue_instr_q;
    assign bus.issue_valid = issue_valid_q;
    assign bus.busy        = (fifo_count != '0) || sb_any;
    assign bus.issued_cnt  = issued_q;
    assign bus.stall_cnt   = stall_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_pipeline_scheduler.sv
// Bench for pipeline_scheduler: a cycle table for the plain and RAW streams,
// then directed sequences for full buffer, flush, reset and counter wrap.
module tb_pipeline_scheduler;
    import pipeline_scheduler_pkg::*;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    pipeline_scheduler_if bus_if ();
    sched_state_t dbg_state;

    pipeline_scheduler #(.DEPTH(4), .HAZARD_WIN(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    localparam logic [16:0] I_A  = 17'b00_00100_00000_00001;
    localparam logic [16:0] I_B  = 17'b01_00101_00001_00010;
    localparam logic [16:0] I_C  = 17'b10_00110_00010_00011;
    localparam logic [16:0] I_D  = 17'b00_00100_00000_00001;
    localparam logic [16:0] I_E  = 17'b01_00101_00100_00010;
    localparam logic [16:0] I_W  = 17'b00_00111_01010_01011;
    localparam logic [16:0] I_F0 = 17'b00_01000_00111_01100;
    localparam logic [16:0] I_F1 = 17'b00_01001_01100_01101;
    localparam logic [16:0] I_F2 = 17'b00_01010_01100_01101;
    localparam logic [16:0] I_F3 = 17'b00_01011_01100_01101;
    localparam logic [16:0] I_F4 = 17'b00_01100_01100_01101;
    localparam logic [16:0] I_P0 = 17'b00_01101_01110_01111;
    localparam logic [16:0] I_P1 = 17'b00_01110_01101_01111;
    localparam logic [16:0] I_P2 = 17'b00_01111_01110_10000;
    localparam logic [16:0] I_P3 = 17'b00_10001_10010_10011;
    localparam logic [16:0] I_P4 = 17'b00_10100_10010_10011;
    localparam logic [16:0] I_Q0 = 17'b00_10000_00001_00010;
    localparam logic [16:0] I_Q1 = 17'b00_10001_10000_00011;
    localparam logic [16:0] I_R  = 17'b00_00001_00010_00011;

    typedef struct {
        logic         vin;
        logic [16:0]  instr;
        logic         flush;
        logic         e_valid;
        logic [16:0]  e_instr;
        logic         e_ready;
        logic         e_busy;
        logic [15:0]  e_issued;
        logic [15:0]  e_stall;
        sched_state_t e_state;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sb_en    = 1'b0;
    logic [16:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vin, input logic [16:0] instr, input logic fl);
        bus_if.in_valid = vin;
        bus_if.in_instr = instr;
        bus_if.flush    = fl;
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (sb_en && bus_if.issue_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got %05h expected none", bus_if.issue_instr);
            end else begin
                check("issue_order", 32'(bus_if.issue_instr), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},  32'(dbg_state),            32'(S_IDLE));
        check({tag, "_valid"},  32'(bus_if.issue_valid),   32'd0);
        check({tag, "_instr"},  32'(bus_if.issue_instr),   32'(BUBBLE));
        check({tag, "_busy"},   32'(bus_if.busy),          32'd0);
        check({tag, "_ready"},  32'(bus_if.in_ready),      32'd0);
        check({tag, "_issued"}, 32'(bus_if.issued_cnt),    32'd0);
        check({tag, "_stall"},  32'(bus_if.stall_cnt),     32'd0);
    endtask

    initial begin
        // vin instr flush | valid instr ready busy issued stall state
        vecs[0]  = '{1'b1, I_A,   1'b0, 1'b0, BUBBLE, 1'b1, 1'b1, 16'd0, 16'd0, S_IDLE};
        vecs[1]  = '{1'b1, I_B,   1'b0, 1'b0, BUBBLE, 1'b1, 1'b1, 16'd0, 16'd0, S_ISSUE};
        vecs[2]  = '{1'b1, I_C,   1'b0, 1'b1, I_A,    1'b1, 1'b1, 16'd1, 16'd0, S_ISSUE};
        vecs[3]  = '{1'b0, 17'd0, 1'b0, 1'b1, I_B,    1'b1, 1'b1, 16'd2, 16'd0, S_ISSUE};
        vecs[4]  = '{1'b0, 17'd0, 1'b0, 1'b1, I_C,    1'b1, 1'b1, 16'd3, 16'd0, S_ISSUE};
        vecs[5]  = '{1'b0, 17'd0, 1'b0, 1'b0, BUBBLE, 1'b1, 1'b1, 16'd3, 16'd0, S_IDLE};
        vecs[6]  = '{1'b0, 17'd0, 1'b0, 1'b0, BUBBLE, 1'b1, 1'b0, 16'd3, 16'd0, S_IDLE};
        vecs[7]  = '{1'b1, I_D,   1'b0, 1'b0, BUBBLE, 1'b1, 1'b1, 16'd3, 16'd0, S_IDLE};
        vecs[8]  = '{1'b1, I_E,   1'b0, 1'b0, BUBBLE, 1'b1, 1'b1, 16'd3, 16'd0, S_ISSUE};
        vecs[9]  = '{1'b0, 17'd0, 1'b0, 1'b1, I_D,    1'b1, 1'b1, 16'd4, 16'd0, S_ISSUE};
        vecs[10] = '{1'b0, 17'd0, 1'b0, 1'b0, BUBBLE, 1'b1, 1'b1, 16'd4, 16'd1, S_STALL};
        vecs[11] = '{1'b0, 17'd0, 1'b0, 1'b0, BUBBLE, 1'b1, 1'b1, 16'd4, 16'd2, S_STALL};
        vecs[12] = '{1'b0, 17'd0, 1'b0, 1'b1, I_E,    1'b1, 1'b1, 16'd5, 16'd2, S_ISSUE};
        vecs[13] = '{1'b0, 17'd0, 1'b0, 1'b0, BUBBLE, 1'b1, 1'b1, 16'd5, 16'd2, S_IDLE};
        vecs[14] = '{1'b0, 17'd0, 1'b0, 1'b0, BUBBLE, 1'b1, 1'b0, 16'd5, 16'd2, S_IDLE};

        // Reset state
        reset_n = 1'b0;
        drive(1'b0, 17'd0, 1'b0);
        step();
        step();
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Independent stream followed by a RAW pair, cycle by cycle
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].vin, vecs[i].instr, vecs[i].flush);
            step();
            check($sformatf("v%0d_valid", i),  32'(bus_if.issue_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_instr", i),  32'(bus_if.issue_instr), 32'(vecs[i].e_instr));
            check($sformatf("v%0d_ready", i),  32'(bus_if.in_ready),    32'(vecs[i].e_ready));
            check($sformatf("v%0d_busy", i),   32'(bus_if.busy),        32'(vecs[i].e_busy));
            check($sformatf("v%0d_issued", i), 32'(bus_if.issued_cnt),  32'(vecs[i].e_issued));
            check($sformatf("v%0d_stall", i),  32'(bus_if.stall_cnt),   32'(vecs[i].e_stall));
            check($sformatf("v%0d_state", i),  32'(dbg_state),          32'(vecs[i].e_state));
        end

        // Full buffer: the head waits on W, four words fill the FIFO, the fifth bounces
        sb_en = 1'b1;
        exp_q = '{I_W, I_F0, I_F1, I_F2, I_F3};
        drive(1'b1, I_W, 1'b0);  step();
        drive(1'b1, I_F0, 1'b0); step();
        drive(1'b1, I_F1, 1'b0); step();
        drive(1'b1, I_F2, 1'b0); step();
        check("full_ready_three", 32'(bus_if.in_ready), 32'd1);
        drive(1'b1, I_F3, 1'b0); step();
        check("full_ready_four", 32'(bus_if.in_ready), 32'd0);
        check("full_state", 32'(dbg_state), 32'(S_STALL));
        drive(1'b1, I_F4, 1'b0); step();
        drive(1'b0, 17'd0, 1'b0);
        repeat (8) step();
        check("full_all_issued", 32'(exp_q.size()), 32'd0);
        check("full_issued_cnt", 32'(bus_if.issued_cnt), 32'd10);
        check("full_stall_cnt", 32'(bus_if.stall_cnt), 32'd4);
        check("full_busy_done", 32'(bus_if.busy), 32'd0);

        // Flush with three words buffered and P1 in flight
        exp_q = '{I_P0, I_P1};
        drive(1'b1, I_P0, 1'b0); step();
        drive(1'b1, I_P1, 1'b0); step();
        drive(1'b1, I_P2, 1'b0); step();
        drive(1'b1, I_P3, 1'b0); step();
        check("flush_pre_state", 32'(dbg_state), 32'(S_STALL));
        drive(1'b0, 17'd0, 1'b0); step();
        drive(1'b1, I_P4, 1'b0); step();
        check("flush_pre_issue", 32'(bus_if.issue_valid), 32'd1);
        drive(1'b1, I_R, 1'b1); step();
        check("flush_drain1_state", 32'(dbg_state), 32'(S_DRAIN));
        check("flush_drain1_ready", 32'(bus_if.in_ready), 32'd0);
        check("flush_drain1_valid", 32'(bus_if.issue_valid), 32'd0);
        check("flush_drain1_busy", 32'(bus_if.busy), 32'd1);
        drive(1'b0, 17'd0, 1'b0); step();
        check("flush_drain2_state", 32'(dbg_state), 32'(S_DRAIN));
        check("flush_drain2_busy", 32'(bus_if.busy), 32'd0);
        step();
        check("flush_idle_state", 32'(dbg_state), 32'(S_IDLE));
        check("flush_idle_ready", 32'(bus_if.in_ready), 32'd1);
        repeat (4) step();
        check("flush_all_issued", 32'(exp_q.size()), 32'd0);
        check("flush_issued_cnt", 32'(bus_if.issued_cnt), 32'd12);
        check("flush_stall_cnt", 32'(bus_if.stall_cnt), 32'd6);
        check("flush_busy_done", 32'(bus_if.busy), 32'd0);

        // Reset while stalled on Q1
        exp_q = '{I_Q0};
        drive(1'b1, I_Q0, 1'b0); step();
        drive(1'b1, I_Q1, 1'b0); step();
        drive(1'b0, 17'd0, 1'b0); step();
        step();
        check("rst_pre_state", 32'(dbg_state), 32'(S_STALL));
        check("rst_pre_stall", 32'(bus_if.stall_cnt), 32'd7);
        reset_n = 1'b0;
        step();
        check_reset_outputs("rst_mid");
        reset_n = 1'b1;
        repeat (5) step();
        check("rst_discard", 32'(exp_q.size()), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);

        // issued_cnt wraps from FFFF to 0
        force dut.issued_q = 16'hFFFF;
        #1;
        release dut.issued_q;
        check("wrap_preload", 32'(bus_if.issued_cnt), 32'h0000FFFF);
        exp_q = '{I_R};
        drive(1'b1, I_R, 1'b0); step();
        drive(1'b0, 17'd0, 1'b0); step();
        step();
        check("wrap_valid", 32'(bus_if.issue_valid), 32'd1);
        check("wrap_issued_cnt", 32'(bus_if.issued_cnt), 32'd0);
        repeat (3) step();
        check("wrap_all_issued", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
